// File: rtl/cy_stripe_resp_pkg.sv
// Shared types and constants for the cy_stripe_resp AXI memory endpoint.
package cy_stripe_resp_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam int         BEAT_BYTES      = 64;

    localparam int ADDR_W = 64;
    localparam int ID_W   = 8;
    localparam int LEN_W  = 8;
    localparam int DATA_W = BEAT_BYTES * 8;
    localparam int STRB_W = BEAT_BYTES;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    // An offset hits the window when its word number is below the RAM depth.
    function automatic logic in_window(input logic [ADDR_W-1:0] off, input int depth_log2);
        return (off >> (6 + depth_log2)) == '0;
    endfunction

endpackage

// File: rtl/axi_bus_t.sv
// AXI4 physical-address bus; the master modport is the responder's view of it.
interface axi_bus_t;
    import cy_stripe_resp_pkg::*;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        input  arid, araddr, arlen, arvalid,
        input  awid, awaddr, awlen, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  rready, bready,
        output arready, awready, wready,
        output rid, rdata, rresp, rlast, rvalid,
        output bid, bresp, bvalid
    );
endinterface

// File: rtl/cy_resp_ram.sv
// Backing store: 64-byte words, byte-enabled write, registered read that returns pre-write data.
module cy_resp_ram
    import cy_stripe_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  ren,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [STRB_W-1:0]     wstrb
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // rdata only moves on ren so an unconsumed word survives a stalled output.
    always_ff @(posedge clk) begin
        if (ren) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            for (int i = 0; i < BEAT_BYTES; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/cy_stripe_resp.sv
// AXI4 memory endpoint serving a programmable address window from on-chip RAM.
module cy_stripe_resp
    import cy_stripe_resp_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [63:0] INIT_BASE  = 64'h0,
    parameter logic [31:0] SR_ADDR    = 32'h38
) (
    input  logic      clk,
    input  logic      rst,
    input  SoftRegReq sr_req,
    axi_bus_t.master  phys_m
);

    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

    logic [63:0] base;

    logic                  ram_ren;
    logic [DEPTH_LOG2-1:0] ram_raddr;
    logic [DATA_W-1:0]     ram_q;
    logic                  ram_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            base <= INIT_BASE;
        end else if (sr_req.valid && sr_req.isWrite && sr_req.addr == SR_ADDR) begin
            base <= sr_req.data;
        end
    end

    rd_state_e             rd_state, rd_next;
    logic [ID_W-1:0]       rd_id;
    logic                  rd_err;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [LEN_W-1:0]      rd_issue_left;
    logic [LEN_W:0]        rd_out_left;
    logic                  rd_q_valid;
    logic [ADDR_W-1:0]     ar_off;
    logic                  ar_hit, ar_fire, r_fire, r_load, r_issue;

    assign ar_off  = phys_m.araddr - base;
    assign ar_hit  = in_window(ar_off, DEPTH_LOG2);
    assign ar_fire = phys_m.arvalid && phys_m.arready;
    assign r_fire  = phys_m.rvalid && phys_m.rready;

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_fire) rd_next = R_BURST;
            R_BURST: if (r_fire && phys_m.rlast) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    // RAM word register plus beat register form a two-deep pipe, so reads keep flowing under backpressure.
    always_comb begin
        r_load    = 1'b0;
        r_issue   = 1'b0;
        ram_ren   = 1'b0;
        ram_raddr = rd_idx;
        case (rd_state)
            R_IDLE: begin
                ram_ren   = ar_fire;
                ram_raddr = ar_off[6 +: DEPTH_LOG2];
            end
            R_BURST: begin
                r_load  = rd_q_valid && (!phys_m.rvalid || phys_m.rready);
                r_issue = (rd_issue_left != '0) && (!rd_q_valid || r_load);
                ram_ren = r_issue;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state       <= R_IDLE;
            phys_m.arready <= 1'b0;
            phys_m.rvalid  <= 1'b0;
            phys_m.rlast   <= 1'b0;
            phys_m.rdata   <= '0;
            phys_m.rresp   <= AXI_RESP_OKAY;
            phys_m.rid     <= '0;
            rd_id          <= '0;
            rd_err         <= 1'b0;
            rd_idx         <= '0;
            rd_issue_left  <= '0;
            rd_out_left    <= '0;
            rd_q_valid     <= 1'b0;
        end else begin
            rd_state       <= rd_next;
            phys_m.arready <= (rd_next == R_IDLE);
            if (ar_fire) begin
                rd_id         <= phys_m.arid;
                rd_err        <= !ar_hit;
                rd_idx        <= ar_off[6 +: DEPTH_LOG2] + IDX_ONE;
                rd_issue_left <= phys_m.arlen;
                rd_out_left   <= {1'b0, phys_m.arlen} + 9'd1;
                rd_q_valid    <= 1'b1;
            end else begin
                if (r_issue) begin
                    rd_idx        <= rd_idx + IDX_ONE;
                    rd_issue_left <= rd_issue_left - 8'd1;
                    rd_q_valid    <= 1'b1;
                end else if (r_load) begin
                    rd_q_valid <= 1'b0;
                end
            end
            if (r_load) begin
                phys_m.rvalid <= 1'b1;
                phys_m.rdata  <= rd_err ? '0 : ram_q;
                phys_m.rresp  <= rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                phys_m.rid    <= rd_id;
                phys_m.rlast  <= (rd_out_left == 9'd1);
                rd_out_left   <= rd_out_left - 9'd1;
            end else if (r_fire) begin
                phys_m.rvalid <= 1'b0;
                phys_m.rlast  <= 1'b0;
            end
        end
    end

    wr_state_e             wr_state, wr_next;
    logic [ID_W-1:0]       wr_id;
    logic                  wr_err;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [LEN_W:0]        wr_expect, wr_cnt, wr_cnt_inc;
    logic [ADDR_W-1:0]     aw_off;
    logic                  aw_hit, aw_fire, w_fire, b_fire;

    assign aw_off     = phys_m.awaddr - base;
    assign aw_hit     = in_window(aw_off, DEPTH_LOG2);
    assign aw_fire    = phys_m.awvalid && phys_m.awready;
    assign w_fire     = phys_m.wvalid && phys_m.wready;
    assign b_fire     = phys_m.bvalid && phys_m.bready;
    assign wr_cnt_inc = (wr_cnt == '1) ? wr_cnt : wr_cnt + 9'd1;

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (aw_fire) wr_next = W_DATA;
            W_DATA:  if (w_fire && phys_m.wlast) wr_next = W_RESP;
            W_RESP:  if (b_fire) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        ram_we = (wr_state == W_DATA) && w_fire && !wr_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state       <= W_IDLE;
            phys_m.awready <= 1'b0;
            phys_m.wready  <= 1'b0;
            phys_m.bvalid  <= 1'b0;
            phys_m.bresp   <= AXI_RESP_OKAY;
            phys_m.bid     <= '0;
            wr_id          <= '0;
            wr_err         <= 1'b0;
            wr_idx         <= '0;
            wr_expect      <= '0;
            wr_cnt         <= '0;
        end else begin
            wr_state       <= wr_next;
            phys_m.awready <= (wr_next == W_IDLE);
            phys_m.wready  <= (wr_next == W_DATA);
            phys_m.bvalid  <= (wr_next == W_RESP);
            if (aw_fire) begin
                wr_id     <= phys_m.awid;
                wr_err    <= !aw_hit;
                wr_idx    <= aw_off[6 +: DEPTH_LOG2];
                wr_expect <= {1'b0, phys_m.awlen} + 9'd1;
                wr_cnt    <= '0;
            end
            if (w_fire) begin
                wr_idx <= wr_idx + IDX_ONE;
                wr_cnt <= wr_cnt_inc;
                if (phys_m.wlast) begin
                    phys_m.bid   <= wr_id;
                    phys_m.bresp <= (wr_err || wr_cnt_inc != wr_expect) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                end
            end
        end
    end

    cy_resp_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .ren   (ram_ren),
        .raddr (ram_raddr),
        .rdata (ram_q),
        .we    (ram_we),
        .waddr (wr_idx),
        .wdata (phys_m.wdata),
        .wstrb (phys_m.wstrb)
    );

endmodule
